proc_n: RTL



---
 rtl/proc_pkg.sv | 43 ++++
 rtl/dec3to8.sv | 9 +
 rtl/regn.sv | 17 +
 rtl/proc_n.sv | 130 +++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for proc_n: opcodes, step encodings and the ALU function.
// The ALU works on ALU_W-bit operands so one function serves any N up to ALU_W-1.
package proc_pkg;

   localparam logic [2:0] MV   = 3'b000;
   localparam logic [2:0] MVI  = 3'b001;
   localparam logic [2:0] ADD  = 3'b010;
   localparam logic [2:0] SUB  = 3'b011;
   localparam logic [2:0] AND  = 3'b100;
   localparam logic [2:0] OR   = 3'b101;
   localparam logic [2:0] XOR  = 3'b110;
   localparam logic [2:0] MVNZ = 3'b111;

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

   localparam int ALU_W = 64;

   typedef struct packed {
      logic             carry;
      logic [ALU_W-1:0] res;
   } alu_t;

   // Operands are zero-extended, so bit w of the wide result is the carry (add)
   // or the borrow (sub) of a w-bit operation.
   function automatic alu_t alu_op(input logic [2:0] op, input logic [ALU_W-1:0] a,
                                   input logic [ALU_W-1:0] b, input logic [6:0] w);
      logic [ALU_W:0] full;
      alu_t           o;
      full = '0;
      case (op)
         ADD:     full = {1'b0, a} + {1'b0, b};
         SUB:     full = {1'b0, a} - {1'b0, b};
         AND:     full = {1'b0, a & b};
         OR:      full = {1'b0, a | b};
         XOR:     full = {1'b0, a ^ b};
         default: full = '0;
      endcase
      o.res   = full[ALU_W-1:0];
      o.carry = (op == ADD || op == SUB) ? full[w] : 1'b0;
      return o;
   endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder for register selection; purely combinational.
module dec3to8 (
   input  logic [2:0] w,
   output logic [7:0] y
);

   assign y = 8'b1 << w;

endmodule

// File: rtl/regn.sv
// n-bit load-enable register with asynchronous active-high clear; one cycle load latency.
module regn #(
   parameter int n = 16
) (
   input  logic         clock,
   input  logic         rst,
   input  logic         en,
   input  logic [n-1:0] d,
   output logic [n-1:0] q
);

   always_ff @(posedge clock or posedge rst) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/proc_n.sv
// Multicycle N-bit processor: one instruction per Run/Done handshake, 2 cycles (moves) or 4 (ALU).
// Run is sampled only in T0; optional {Z,C} Flags output when PROC_FLAGS_EN is defined.
module proc_n
   import proc_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic [N-1:0] DIN,
   input  logic         Run,
   output logic         Done,
   output logic [N-1:0] BusWires
`ifdef PROC_FLAGS_EN
   ,
   output logic [1:0]   Flags
`endif
);

   step_t       tstep;
   logic [8:0]  ir;
   logic [2:0]  op;
   logic [7:0]  xsel, ysel;
   logic [7:0]  rin, rout;
   logic        ain, gin, gout, dinout, is_alu;
   logic [N-1:0] r [8];
   logic [N-1:0] a, g, bus;
   logic        z;
   alu_t        alu_out;

   assign op     = ir[8:6];
   assign is_alu = !(op == MV || op == MVI || op == MVNZ);

   dec3to8 u_decx (.w(ir[5:3]), .y(xsel));
   dec3to8 u_decy (.w(ir[2:0]), .y(ysel));

   regn #(.n(9)) u_ir (.clock(Clock), .rst(Reset), .en(tstep == T0 && Run), .d(DIN[8:0]), .q(ir));
   regn #(.n(N)) u_a  (.clock(Clock), .rst(Reset), .en(ain), .d(bus), .q(a));
   regn #(.n(N)) u_g  (.clock(Clock), .rst(Reset), .en(gin), .d(alu_out.res[N-1:0]), .q(g));

   for (genvar i = 0; i < 8; i++) begin : g_reg
      regn #(.n(N)) u_r (.clock(Clock), .rst(Reset), .en(rin[i]), .d(bus), .q(r[i]));
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         tstep <= T0;
      end else begin
         case (tstep)
            T0:      if (Run) tstep <= T1;
            T1:      tstep <= is_alu ? T2 : T0;
            T2:      tstep <= T3;
            default: tstep <= T0;
         endcase
      end
   end

   always_comb begin
      rin    = '0;
      rout   = '0;
      ain    = 1'b0;
      gin    = 1'b0;
      gout   = 1'b0;
      dinout = 1'b0;
      Done   = 1'b0;
      case (tstep)
         T1: begin
            if (op == MV) begin
               rout = ysel;
               rin  = xsel;
               Done = 1'b1;
            end else if (op == MVI) begin
               dinout = 1'b1;
               rin    = xsel;
               Done   = 1'b1;
            end else if (op == MVNZ) begin
               rout = ysel;
               rin  = z ? 8'h00 : xsel;
               Done = 1'b1;
            end else begin
               rout = xsel;
               ain  = 1'b1;
            end
         end
         T2: begin
            rout = ysel;
            gin  = 1'b1;
         end
         T3: begin
            gout = 1'b1;
            rin  = xsel;
            Done = 1'b1;
         end
         default: ;
      endcase
   end

   // Lowest-numbered register wins, then G, then DIN.
   always_comb begin
      bus = '0;
      if (dinout) bus = DIN;
      if (gout)   bus = g;
      for (int i = 7; i >= 0; i--)
         if (rout[i]) bus = r[i];
   end

   assign BusWires = bus;
   assign alu_out  = alu_op(op, ALU_W'(a), ALU_W'(bus), 7'(N));

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)    z <= 1'b0;
      else if (gin) z <= (alu_out.res[N-1:0] == '0);
   end

`ifdef PROC_FLAGS_EN
   logic c;
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)    c <= 1'b0;
      else if (gin) c <= alu_out.carry;
   end
   assign Flags = {z, c};

   logic unused_alu;
   assign unused_alu = ^alu_out.res[ALU_W-1:N];
`else
   logic unused_alu;
   assign unused_alu = ^{alu_out.carry, alu_out.res[ALU_W-1:N]};
`endif

endmodule
